// File: rtl/ebus_xfer.sv
// EBOX-side EBUS initiator: arbitrates, drives CS/F/data, handshakes DEMAND/XFER, returns read data.
// Every output is a registered decode of the previous cycle's state; each wait is bounded by TIMEOUT.
module ebus_xfer #(
   parameter int SETUP_CYC = 2,
   parameter int TIMEOUT   = 200
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        start,
   input  logic [2:0]  func,
   input  logic [6:0]  dev,
   input  logic [35:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [35:0] rdata,
   output logic        timeout,
   output logic        EBUS_REQ,
   input  logic        EBUS_GRANT,
   output logic [6:0]  EBUS_CS,
   output logic [2:0]  EBUS_F,
   output logic        EBUS_DEMAND,
   input  logic        EBUS_XFER,
   input  logic [35:0] EBUS_DATA_IN,
   output logic [35:0] EBUS_DATA_OUT,
   output logic        EBUS_DATA_OE
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_SETUP,
      S_DEMAND,
      S_RELEASE,
      S_DONE
   } state_t;

   localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
   localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [2:0]  func_q;
   logic [6:0]  dev_q;
   logic [35:0] wdata_q;
   logic        own_bus;
   logic        is_write;

   assign own_bus  = (state == S_SETUP) || (state == S_DEMAND) || (state == S_RELEASE);
   assign is_write = ~func_q[0];

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state         <= S_IDLE;
         wait_cnt      <= '0;
         func_q        <= '0;
         dev_q         <= '0;
         wdata_q       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         rdata         <= '0;
         timeout       <= 1'b0;
         EBUS_REQ      <= 1'b0;
         EBUS_CS       <= '0;
         EBUS_F        <= '0;
         EBUS_DEMAND   <= 1'b0;
         EBUS_DATA_OUT <= '0;
         EBUS_DATA_OE  <= 1'b0;
      end else begin
         // Bus outputs lag the state by one cycle, so each sampled event shows up one edge later.
         busy          <= (state != S_IDLE);
         done          <= (state == S_DONE);
         EBUS_REQ      <= (state == S_REQ) || own_bus;
         EBUS_CS       <= own_bus ? dev_q : '0;
         EBUS_F        <= own_bus ? func_q : '0;
         EBUS_DEMAND   <= (state == S_DEMAND);
         EBUS_DATA_OE  <= own_bus && is_write;
         EBUS_DATA_OUT <= (own_bus && is_write) ? wdata_q : '0;

         wait_cnt <= (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

         case (state)
            S_IDLE: begin
               wait_cnt <= '0;
               if (start && !func[2]) begin
                  func_q  <= func;
                  dev_q   <= dev;
                  wdata_q <= wdata;
                  timeout <= 1'b0;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (EBUS_GRANT) begin
                  state    <= S_SETUP;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  timeout  <= 1'b1;
                  state    <= S_DONE;
                  wait_cnt <= '0;
               end
            end
            S_SETUP: begin
               if (wait_cnt == SETUP_LAST) begin
                  state    <= S_DEMAND;
                  wait_cnt <= '0;
               end
            end
            S_DEMAND: begin
               if (EBUS_XFER) begin
                  if (func_q[0])
                     rdata <= EBUS_DATA_IN;
                  state    <= S_RELEASE;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  timeout  <= 1'b1;
                  state    <= S_RELEASE;
                  wait_cnt <= '0;
               end
            end
            S_RELEASE: begin
               if (!EBUS_XFER) begin
                  state    <= S_DONE;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  timeout  <= 1'b1;
                  state    <= S_DONE;
                  wait_cnt <= '0;
               end
            end
            S_DONE: begin
               state    <= S_IDLE;
               wait_cnt <= '0;
            end
            default: begin
               state    <= S_IDLE;
               wait_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ebus_xfer.sv
// Directed bench for ebus_xfer (SETUP_CYC=2, TIMEOUT=10): write, read, no-device, starvation, stuck XFER, abort.
module tb_ebus_xfer;

   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  func = '0;
   logic [6:0]  dev = '0;
   logic [35:0] wdata = '0;
   logic        busy, done, timeout;
   logic [35:0] rdata;
   logic        EBUS_REQ;
   logic        EBUS_GRANT = 1'b0;
   logic [6:0]  EBUS_CS;
   logic [2:0]  EBUS_F;
   logic        EBUS_DEMAND;
   logic        EBUS_XFER = 1'b0;
   logic [35:0] EBUS_DATA_IN = '0;
   logic [35:0] EBUS_DATA_OUT;
   logic        EBUS_DATA_OE;

   int n_pass = 0;
   int n_total = 0;
   int n_dem = 0, n_req = 0, n_done = 0, n_oe = 0, n_cs = 0, n_csnd = 0;
   int s_dem, s_req, s_done, s_oe, s_cs, s_csnd;

   ebus_xfer #(.SETUP_CYC(2), .TIMEOUT(10)) dut (
      .clk           (clk),
      .RESET         (RESET),
      .start         (start),
      .func          (func),
      .dev           (dev),
      .wdata         (wdata),
      .busy          (busy),
      .done          (done),
      .rdata         (rdata),
      .timeout       (timeout),
      .EBUS_REQ      (EBUS_REQ),
      .EBUS_GRANT    (EBUS_GRANT),
      .EBUS_CS       (EBUS_CS),
      .EBUS_F        (EBUS_F),
      .EBUS_DEMAND   (EBUS_DEMAND),
      .EBUS_XFER     (EBUS_XFER),
      .EBUS_DATA_IN  (EBUS_DATA_IN),
      .EBUS_DATA_OUT (EBUS_DATA_OUT),
      .EBUS_DATA_OE  (EBUS_DATA_OE)
   );

   always #5 clk = ~clk;

   // Cycle counters sampled mid-cycle
   always @(negedge clk) begin
      if (EBUS_DEMAND) n_dem++;
      if (EBUS_REQ) n_req++;
      if (done) n_done++;
      if (EBUS_DATA_OE) n_oe++;
      if (EBUS_CS != 7'd0) n_cs++;
      if (EBUS_CS != 7'd0 && !EBUS_DEMAND) n_csnd++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      s_dem = n_dem; s_req = n_req; s_done = n_done;
      s_oe = n_oe; s_cs = n_cs; s_csnd = n_csnd;
   endtask

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0o required %0o", tag, obs, exp);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b required %b", tag, obs, exp);
   endtask

   initial begin
      // Reset values
      tick(); tick();
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk("rst_rdata", rdata, 36'd0);
      chk1("rst_timeout", timeout, 1'b0);
      chk1("rst_req", EBUS_REQ, 1'b0);
      chk("rst_cs", 36'(EBUS_CS), 36'd0);
      chk("rst_f", 36'(EBUS_F), 36'd0);
      chk1("rst_demand", EBUS_DEMAND, 1'b0);
      chk("rst_dout", EBUS_DATA_OUT, 36'd0);
      chk1("rst_oe", EBUS_DATA_OE, 1'b0);
      RESET = 1'b0;
      tick();

      // CONO happy path: XFER sampled 3 edges after DEMAND shows, dropped 1 cycle after DEMAND falls
      snap();
      func = 3'd0; dev = 7'o000; wdata = 36'o000000_000100; EBUS_GRANT = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      chk1("cono_req_lag", EBUS_REQ, 1'b0);
      tick();
      chk1("cono_req", EBUS_REQ, 1'b1);
      chk1("cono_busy", busy, 1'b1);
      tick();
      chk1("cono_oe_setup", EBUS_DATA_OE, 1'b1);
      chk("cono_dout", EBUS_DATA_OUT, 36'o000000_000100);
      chk1("cono_dem_setup", EBUS_DEMAND, 1'b0);
      tick(); tick();
      chk1("cono_dem_rise", EBUS_DEMAND, 1'b1);
      tick(); tick(); EBUS_XFER = 1'b1;
      tick();
      chk1("cono_dem_hold", EBUS_DEMAND, 1'b1);
      tick();
      chk1("cono_dem_fall", EBUS_DEMAND, 1'b0);
      chk1("cono_oe_release", EBUS_DATA_OE, 1'b1);
      tick(); EBUS_XFER = 1'b0;
      tick(); tick();
      chk1("cono_done", done, 1'b1);
      chk1("cono_oe_done", EBUS_DATA_OE, 1'b0);
      chk1("cono_req_done", EBUS_REQ, 1'b0);
      tick();
      chk1("cono_done_pulse", done, 1'b0);
      chk1("cono_busy_end", busy, 1'b0);
      chk("cono_dem_cycles", 36'(n_dem - s_dem), 36'd4);
      chk("cono_oe_cycles", 36'(n_oe - s_oe), 36'd9);
      chk("cono_done_cnt", 36'(n_done - s_done), 36'd1);
      chk1("cono_timeout", timeout, 1'b0);

      // DATAI read
      snap();
      func = 3'd3; dev = 7'o042; wdata = 36'o777; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();
      chk("datai_cs", 36'(EBUS_CS), 36'o42);
      chk("datai_f", 36'(EBUS_F), 36'd3);
      chk1("datai_oe", EBUS_DATA_OE, 1'b0);
      chk("datai_dout", EBUS_DATA_OUT, 36'd0);
      tick(); tick();
      chk1("datai_dem", EBUS_DEMAND, 1'b1);
      EBUS_DATA_IN = 36'o123456_654321; EBUS_XFER = 1'b1;
      tick();
      EBUS_XFER = 1'b0; EBUS_DATA_IN = 36'o7;
      tick();
      chk1("datai_dem_fall", EBUS_DEMAND, 1'b0);
      chk("datai_rdata", rdata, 36'o123456_654321);
      tick();
      chk1("datai_done", done, 1'b1);
      tick();
      chk1("datai_busy_end", busy, 1'b0);
      chk("datai_rdata_held", rdata, 36'o123456_654321);
      chk("datai_oe_cycles", 36'(n_oe - s_oe), 36'd0);
      chk("datai_done_cnt", 36'(n_done - s_done), 36'd1);

      // No device: DEMAND times out, rdata untouched
      snap();
      func = 3'd1; dev = 7'd5; EBUS_DATA_IN = 36'o555; start = 1'b1;
      tick(); start = 1'b0;
      repeat (20) tick();
      chk("nodev_dem_cycles", 36'(n_dem - s_dem), 36'd10);
      chk("nodev_done_cnt", 36'(n_done - s_done), 36'd1);
      chk1("nodev_timeout", timeout, 1'b1);
      chk("nodev_rdata", rdata, 36'o123456_654321);
      chk1("nodev_busy_end", busy, 1'b0);

      // Grant starvation; this start also clears the sticky timeout
      snap();
      func = 3'd2; dev = 7'd9; EBUS_GRANT = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      chk1("starve_timeout_clr", timeout, 1'b0);
      repeat (15) tick();
      chk("starve_req_cycles", 36'(n_req - s_req), 36'd10);
      chk("starve_cs_cycles", 36'(n_cs - s_cs), 36'd0);
      chk("starve_oe_cycles", 36'(n_oe - s_oe), 36'd0);
      chk("starve_done_cnt", 36'(n_done - s_done), 36'd1);
      chk1("starve_timeout", timeout, 1'b1);
      chk1("starve_busy_end", busy, 1'b0);
      EBUS_GRANT = 1'b1;

      // Stuck XFER: RELEASE runs the full TIMEOUT
      snap();
      func = 3'd0; dev = 7'd3; wdata = 36'd1; start = 1'b1;
      tick(); start = 1'b0;
      repeat (4) tick();
      chk1("stuck_dem", EBUS_DEMAND, 1'b1);
      EBUS_XFER = 1'b1;
      repeat (20) tick();
      chk("stuck_dem_cycles", 36'(n_dem - s_dem), 36'd2);
      chk("stuck_cs_nodem_cycles", 36'(n_csnd - s_csnd), 36'd12);
      chk("stuck_done_cnt", 36'(n_done - s_done), 36'd1);
      chk1("stuck_timeout", timeout, 1'b1);
      chk1("stuck_busy_end", busy, 1'b0);
      EBUS_XFER = 1'b0;
      tick();

      // Second start while busy is ignored, then reset aborts in DEMAND
      func = 3'd1; dev = 7'd4; start = 1'b1;
      tick(); start = 1'b0;
      tick();
      func = 3'd2; dev = 7'o77; start = 1'b1;
      tick(); start = 1'b0;
      chk("busy_start_cs", 36'(EBUS_CS), 36'd4);
      chk("busy_start_f", 36'(EBUS_F), 36'd1);
      tick(); tick();
      chk1("abort_dem_before", EBUS_DEMAND, 1'b1);
      RESET = 1'b1;
      #1;
      chk1("abort_dem", EBUS_DEMAND, 1'b0);
      chk("abort_cs", 36'(EBUS_CS), 36'd0);
      chk("abort_f", 36'(EBUS_F), 36'd0);
      chk1("abort_req", EBUS_REQ, 1'b0);
      chk1("abort_busy", busy, 1'b0);
      chk("abort_rdata", rdata, 36'd0);
      tick(); RESET = 1'b0;
      tick();

      // Illegal function code is ignored while idle
      snap();
      func = 3'd5; dev = 7'd6; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();
      chk1("illegal_busy", busy, 1'b0);
      chk("illegal_req_cycles", 36'(n_req - s_req), 36'd0);
      chk("illegal_cs_cycles", 36'(n_cs - s_cs), 36'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
